// File: rtl/alu_pipe_top.sv
// ---------------------------------------------------------------------------
// alu_pipe_top
//   Pipelined ALU between the operand register file and writeback. A single
//   opcode space feeds one registered result bus; valid/ready handshakes on
//   both sides let upstream and downstream stall it. Most opcodes complete in
//   one cycle. DIV with a non-zero divisor runs an iterative restoring divider
//   (one quotient bit per cycle). A user tag travels with every operation.
//
// Ports
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   A, B          operands (DATA_WIDTH)
//   ALU_FUNC      4-bit opcode
//   IN_TAG        user tag, returned with the result
//   IN_VALID      request; transfer on IN_VALID && IN_READY
//   IN_READY      block can accept (combinational, independent of IN_VALID)
//   RES_OUT       2*DATA_WIDTH result
//   OUT_TAG       tag of the current result
//   ZERO_FLAG     RES_OUT == 0
//   CARRY_FLAG    ADD carry-out / SUB borrow, else 0
//   OVF_FLAG      signed overflow on ADD/SUB, else 0
//   ERR_FLAG      divide by zero
//   OUT_VALID     result valid; transfer on OUT_VALID && OUT_READY
//   OUT_READY     consumer accepts
// ---------------------------------------------------------------------------
module alu_pipe_top #(
    parameter int DATA_WIDTH  = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    input  logic [3:0]              ALU_FUNC,
    input  logic [TAG_WIDTH-1:0]    IN_TAG,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [2*DATA_WIDTH-1:0] RES_OUT,
    output logic [TAG_WIDTH-1:0]    OUT_TAG,
    output logic                    ZERO_FLAG,
    output logic                    CARRY_FLAG,
    output logic                    OVF_FLAG,
    output logic                    ERR_FLAG,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_GT   = 4'b1010;
    localparam logic [3:0] OP_LT   = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_ROL  = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [2*W-1:0]       r_res;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_ovf;
    logic                 r_err;
    logic                 r_out_valid;

    logic [W-1:0]         r_div_rem;
    logic [W-1:0]         r_div_quo;
    logic [W-1:0]         r_div_b;
    logic [TAG_WIDTH-1:0] r_div_tag;
    logic [CNT_W-1:0]     r_div_cnt;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic w_accept;
    logic w_div_start;

    assign IN_READY    = !RST && (r_state == ST_IDLE) && (!r_out_valid || OUT_READY);
    assign w_accept    = IN_VALID && IN_READY;
    assign w_div_start = w_accept && (ALU_FUNC == OP_DIV) && (B != '0);

    // ---------------------------------------------------------------------
    // Single-cycle datapath
    // ---------------------------------------------------------------------
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic [W:0]             w_sum;
    logic [W:0]             w_diff;
    logic [2*W-1:0]         w_prod;
    logic [W-1:0]           w_sra;
    logic [W-1:0]           w_rol;
    logic [2*W-1:0]         w_res;
    logic                   w_carry;
    logic                   w_ovf;
    logic                   w_err;
    logic                   w_zero;

    assign w_shamt = B[SHAMT_WIDTH-1:0];
    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} - {1'b0, B};
    assign w_prod  = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    assign w_sra   = $unsigned($signed(A) >>> w_shamt);
    // Rotate by shifting a doubled copy left and keeping the upper half.
    assign w_rol   = W'(({A, A} << w_shamt) >> W);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (ALU_FUNC)
            OP_ADD: begin
                w_res[W:0] = w_sum;
                w_carry     = w_sum[W];
                w_ovf       = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
            end
            OP_SUB: begin
                w_res[W:0] = w_diff;
                w_carry     = w_diff[W];
                w_ovf       = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
            end
            OP_MUL:  w_res = w_prod;
            // Only reached with B == 0; non-zero divisors go to the divider.
            OP_DIV: begin
                w_res = {A, {W{1'b1}}};
                w_err = 1'b1;
            end
            OP_AND:  w_res[W-1:0] = A & B;
            OP_OR:   w_res[W-1:0] = A | B;
            OP_NAND: w_res[W-1:0] = ~(A & B);
            OP_NOR:  w_res[W-1:0] = ~(A | B);
            OP_XOR:  w_res[W-1:0] = A ^ B;
            OP_EQ:   w_res[0]     = (A == B);
            OP_GT:   w_res[0]     = (A > B);
            OP_LT:   w_res[0]     = (A < B);
            OP_SRL:  w_res[W-1:0] = A >> w_shamt;
            OP_SLL:  w_res[W-1:0] = A << w_shamt;
            OP_SRA:  w_res[W-1:0] = w_sra;
            OP_ROL:  w_res[W-1:0] = w_rol;
            default: w_res = '0;
        endcase
    end

    assign w_zero = (w_res == '0);

    // ---------------------------------------------------------------------
    // Restoring divider step: shift in the next dividend bit, try subtract.
    // ---------------------------------------------------------------------
    logic [W:0]   w_div_shift;
    logic [W:0]   w_div_trial;
    logic [W-1:0] w_div_rem_nx;
    logic [W-1:0] w_div_quo_nx;
    logic         w_div_zero;

    assign w_div_shift = {r_div_rem, r_div_quo[W-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_div_b};

    always_comb begin
        w_div_rem_nx = w_div_shift[W-1:0];
        w_div_quo_nx = {r_div_quo[W-2:0], 1'b0};
        // The trial wraps (top bit set) exactly when the divisor did not fit.
        if (!w_div_trial[W]) begin
            w_div_rem_nx = w_div_trial[W-1:0];
            w_div_quo_nx = {r_div_quo[W-2:0], 1'b1};
        end
    end

    assign w_div_zero = ({w_div_rem_nx, w_div_quo_nx} == '0);

    // ---------------------------------------------------------------------
    // Control and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_tag       <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_div_rem   <= '0;
            r_div_quo   <= '0;
            r_div_b     <= '0;
            r_div_tag   <= '0;
            r_div_cnt   <= '0;
        end else begin
            // Consumer took the current result; a new load below overrides.
            if (r_out_valid && OUT_READY)
                r_out_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_div_start) begin
                        r_div_rem <= '0;
                        r_div_quo <= A;
                        r_div_b   <= B;
                        r_div_tag <= IN_TAG;
                        r_div_cnt <= '0;
                        r_state   <= ST_DIV;
                    end else if (w_accept) begin
                        r_res       <= w_res;
                        r_tag       <= IN_TAG;
                        r_zero      <= w_zero;
                        r_carry     <= w_carry;
                        r_ovf       <= w_ovf;
                        r_err       <= w_err;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DIV: begin
                    r_div_rem <= w_div_rem_nx;
                    r_div_quo <= w_div_quo_nx;
                    r_div_cnt <= r_div_cnt + 1'b1;
                    if (r_div_cnt == DIV_LAST) begin
                        r_res       <= {w_div_rem_nx, w_div_quo_nx};
                        r_tag       <= r_div_tag;
                        r_zero      <= w_div_zero;
                        r_carry     <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT_READY ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RES_OUT    = r_res;
    assign OUT_TAG    = r_tag;
    assign ZERO_FLAG  = r_zero;
    assign CARRY_FLAG = r_carry;
    assign OVF_FLAG   = r_ovf;
    assign ERR_FLAG   = r_err;
    assign OUT_VALID  = r_out_valid;

endmodule

// File: tb/tb_alu_pipe_top.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe_top
//   Self-checking bench for alu_pipe_top (DATA_WIDTH=16, TAG_WIDTH=4).
//   Expected results come from a hand-computed vector table and are queued
//   when an operation is accepted, then compared in order as results leave.
//   Hand-written sequences cover divider latency, backpressure and reset
//   during a division.
// ---------------------------------------------------------------------------
module tb_alu_pipe_top;

    localparam int W  = 16;
    localparam int TW = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [3:0]      ALU_FUNC;
    logic [TW-1:0]   IN_TAG;
    logic            IN_VALID;
    logic            IN_READY;
    logic [2*W-1:0]  RES_OUT;
    logic [TW-1:0]   OUT_TAG;
    logic            ZERO_FLAG;
    logic            CARRY_FLAG;
    logic            OVF_FLAG;
    logic            ERR_FLAG;
    logic            OUT_VALID;
    logic            OUT_READY;

    alu_pipe_top #(
        .DATA_WIDTH(W),
        .TAG_WIDTH (TW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUNC  (ALU_FUNC),
        .IN_TAG    (IN_TAG),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .RES_OUT   (RES_OUT),
        .OUT_TAG   (OUT_TAG),
        .ZERO_FLAG (ZERO_FLAG),
        .CARRY_FLAG(CARRY_FLAG),
        .OVF_FLAG  (OVF_FLAG),
        .ERR_FLAG  (ERR_FLAG),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, DIV = 4'h3;
    localparam logic [3:0] AND_ = 4'h4, OR_ = 4'h5, NAND_ = 4'h6, NOR_ = 4'h7;
    localparam logic [3:0] XOR_ = 4'h8, EQ = 4'h9, GT = 4'hA, LT = 4'hB;
    localparam logic [3:0] SRL = 4'hC, SLL = 4'hD, SRA = 4'hE, ROL = 4'hF;

    // flg = {zero, carry, ovf, err}
    typedef struct {
        logic [3:0]     f;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [TW-1:0]  tag;
        logic [2*W-1:0] res;
        logic [3:0]     flg;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] res;
        logic [TW-1:0]  tag;
        logic [3:0]     flg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur_exp;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        s_in_ready;
    logic        s_out_valid;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic v(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [TW-1:0] tg, input logic [2*W-1:0] r, input logic [3:0] fl);
        vec_t x;
        x.f = f; x.a = a; x.b = b; x.tag = tg; x.res = r; x.flg = fl;
        vecs.push_back(x);
    endtask

    // Called just after a falling edge with inputs already driven. Samples
    // the handshake, scores any result leaving, queues any accepted op, and
    // returns at the next falling edge.
    task automatic tick(output bit acc);
        exp_t e;
        logic [63:0] got;
        logic [63:0] want;
        #1;
        s_in_ready  = IN_READY;
        s_out_valid = OUT_VALID;
        if (OUT_VALID && OUT_READY) begin
            got = {24'h0, RES_OUT, OUT_TAG, ZERO_FLAG, CARRY_FLAG, OVF_FLAG, ERR_FLAG};
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got res=%h tag=%h with nothing expected", RES_OUT, OUT_TAG);
            end else begin
                e = sb.pop_front();
                want = {24'h0, e.res, e.tag, e.flg};
                if (got === want) n_pass++;
                else $display("FAIL sb_result: got res/tag/flags %h expected %h", got, want);
            end
        end
        acc = IN_VALID && IN_READY && !RST;
        if (acc) sb.push_back(cur_exp);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tg, input logic [2*W-1:0] r, input logic [3:0] fl,
                         output int unsigned cyc);
        bit acc;
        acc = 1'b0;
        cyc = 0;
        ALU_FUNC = f; A = a; B = b; IN_TAG = tg; IN_VALID = 1'b1;
        cur_exp.res = r; cur_exp.tag = tg; cur_exp.flg = fl;
        while (!acc && cyc < 200) begin
            tick(acc);
            cyc++;
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL issue_timeout: got no accept in %0d cycles expected accept", cyc);
        end
        // Scramble inputs so any sampling outside an accept would show up.
        IN_VALID = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        ALU_FUNC = 4'($urandom);
        IN_TAG   = 4'($urandom);
    endtask

    task automatic drain();
        bit acc;
        int unsigned n;
        n = 0;
        IN_VALID = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            tick(acc);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned total;
        int unsigned lat;
        int unsigned bad;
        int unsigned accs;
        bit acc;

        RST = 1'b1; OUT_READY = 1'b1; IN_VALID = 1'b0;
        A = '0; B = '0; ALU_FUNC = '0; IN_TAG = '0;
        cur_exp.res = '0; cur_exp.tag = '0; cur_exp.flg = '0;

        //      op     A        B        tag    RES            {Z,C,O,E}
        v(ADD,  16'hFFFF, 16'h0001, 4'h3, 32'h0001_0000, 4'b0100);
        v(SUB,  16'h8000, 16'h0001, 4'h1, 32'h0000_7FFF, 4'b0010);
        v(MUL,  16'h1234, 16'h0010, 4'h2, 32'h0001_2340, 4'b0000);
        v(DIV,  16'h00AB, 16'h0000, 4'h4, 32'h00AB_FFFF, 4'b0001);
        v(SRA,  16'h8000, 16'h0004, 4'h5, 32'h0000_F800, 4'b0000);
        v(ROL,  16'h8001, 16'h0001, 4'h6, 32'h0000_0003, 4'b0000);
        v(GT,   16'h0005, 16'h0003, 4'h7, 32'h0000_0001, 4'b0000);
        v(LT,   16'h0005, 16'h0003, 4'h8, 32'h0000_0000, 4'b1000);
        v(ADD,  16'h7FFF, 16'h0001, 4'h9, 32'h0000_8000, 4'b0010);
        v(ADD,  16'h8000, 16'h8000, 4'hA, 32'h0001_0000, 4'b0110);
        v(ADD,  16'hFFFF, 16'hFFFF, 4'hB, 32'h0001_FFFE, 4'b0100);
        v(SUB,  16'h0000, 16'h0001, 4'hC, 32'h0001_FFFF, 4'b0100);
        v(SUB,  16'h0005, 16'h0005, 4'hD, 32'h0000_0000, 4'b1000);
        v(SUB,  16'h7FFF, 16'hFFFF, 4'hE, 32'h0001_8000, 4'b0110);
        v(AND_, 16'hF0F0, 16'h0FF0, 4'hF, 32'h0000_00F0, 4'b0000);
        v(OR_,  16'h1200, 16'h0034, 4'h0, 32'h0000_1234, 4'b0000);
        v(NAND_,16'hFFFF, 16'hFFFF, 4'h1, 32'h0000_0000, 4'b1000);
        v(NOR_, 16'h0000, 16'h0000, 4'h2, 32'h0000_FFFF, 4'b0000);
        v(XOR_, 16'hAAAA, 16'hFFFF, 4'h3, 32'h0000_5555, 4'b0000);
        v(EQ,   16'h1234, 16'h1234, 4'h4, 32'h0000_0001, 4'b0000);
        v(EQ,   16'h1234, 16'h1235, 4'h5, 32'h0000_0000, 4'b1000);
        v(GT,   16'h0003, 16'h0005, 4'h6, 32'h0000_0000, 4'b1000);
        v(LT,   16'h0001, 16'hFFFF, 4'h7, 32'h0000_0001, 4'b0000);
        v(SRL,  16'h8000, 16'h000F, 4'h8, 32'h0000_0001, 4'b0000);
        v(SLL,  16'h0001, 16'h0013, 4'h9, 32'h0000_0008, 4'b0000);
        v(SRA,  16'h4000, 16'h0002, 4'hA, 32'h0000_1000, 4'b0000);
        v(ROL,  16'h1234, 16'h0000, 4'hB, 32'h0000_1234, 4'b0000);
        v(ROL,  16'h1234, 16'h0004, 4'hC, 32'h0000_2341, 4'b0000);
        v(MUL,  16'hFFFF, 16'hFFFF, 4'hD, 32'hFFFE_0001, 4'b0000);
        v(DIV,  16'h0064, 16'h0007, 4'hE, 32'h0002_000E, 4'b0000);
        v(DIV,  16'hFFFF, 16'h0001, 4'hF, 32'h0000_FFFF, 4'b0000);
        v(DIV,  16'h1234, 16'h0100, 4'h0, 32'h0034_0012, 4'b0000);
        v(DIV,  16'h0003, 16'h0005, 4'h1, 32'h0003_0000, 4'b0000);
        v(DIV,  16'h0000, 16'h0005, 4'h2, 32'h0000_0000, 4'b1000);
        v(DIV,  16'hFFFF, 16'h0000, 4'h3, 32'hFFFF_FFFF, 4'b0001);

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        check("rst_in_ready",  64'(IN_READY),  64'd0);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_res",       64'(RES_OUT),   64'd0);
        check("rst_tag",       64'(OUT_TAG),   64'd0);
        check("rst_flags",     64'({ZERO_FLAG, CARRY_FLAG, OVF_FLAG, ERR_FLAG}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Vector table, back-to-back with the consumer always ready
        foreach (vecs[i])
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].flg, cyc);
        drain();

        // Divider latency and input stall
        issue(DIV, 16'd100, 16'd7, 4'h6, 32'h0002_000E, 4'b0000, cyc);
        lat = 0;
        bad = 0;
        for (int unsigned n = 1; n <= 40 && lat == 0; n++) begin
            tick(acc);
            if (s_in_ready && n <= 16) bad++;
            if (s_out_valid) lat = n;
        end
        check("div_latency", 64'(lat), 64'd17);
        check("div_in_ready_low", 64'(bad), 64'd0);
        drain();

        // Backpressure: result must hold and a pending request must wait
        OUT_READY = 1'b0;
        issue(AND_, 16'hF0F0, 16'h0FF0, 4'h8, 32'h0000_00F0, 4'b0000, cyc);
        ALU_FUNC = ADD; A = 16'h0001; B = 16'h0001; IN_TAG = 4'h9; IN_VALID = 1'b1;
        cur_exp.res = 32'h0000_0002; cur_exp.tag = 4'h9; cur_exp.flg = 4'b0000;
        bad  = 0;
        accs = 0;
        for (int unsigned n = 0; n < 5; n++) begin
            tick(acc);
            if (acc) accs++;
            if (s_in_ready || !OUT_VALID || RES_OUT !== 32'h0000_00F0 || OUT_TAG !== 4'h8) bad++;
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        check("bp_no_accept", 64'(accs), 64'd0);
        OUT_READY = 1'b1;
        total = 0;
        issue(ADD,  16'h0001, 16'h0001, 4'h9, 32'h0000_0002, 4'b0000, cyc); total += cyc;
        issue(XOR_, 16'h0F0F, 16'h00FF, 4'hA, 32'h0000_0FF0, 4'b0000, cyc); total += cyc;
        issue(SUB,  16'h0010, 16'h0001, 4'hB, 32'h0000_000F, 4'b0000, cyc); total += cyc;
        issue(OR_,  16'h0100, 16'h0001, 4'hC, 32'h0000_0101, 4'b0000, cyc); total += cyc;
        check("bp_stream_cycles", 64'(total), 64'd4);
        drain();

        // Reset in the middle of a division
        issue(DIV, 16'hFFFF, 16'h0003, 4'h7, 32'h0000_5555, 4'b0000, cyc);
        repeat (8) tick(acc);
        RST = 1'b1;
        #1;
        check("rst_mid_in_ready", 64'(IN_READY), 64'd0);
        @(negedge CLK);
        sb.delete();
        #1;
        check("rst_mid_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_mid_res", 64'(RES_OUT), 64'd0);
        check("rst_mid_flags", 64'({OUT_TAG, ZERO_FLAG, CARRY_FLAG, OVF_FLAG, ERR_FLAG}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        // Any output here would be the aborted division and is scored as unexpected.
        repeat (20) tick(acc);
        #1;
        check("post_rst_in_ready", 64'(IN_READY), 64'd1);
        @(negedge CLK);
        issue(ADD, 16'h1234, 16'h0001, 4'h5, 32'h0000_1235, 4'b0000, cyc);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
